// File: rtl/code_decoder_accum.sv
// Streaming index decoder: registers a one-hot result behind a 1-deep valid/ready
// stage and accumulates decoded indices into a sticky, bit-clearable pending mask.
module code_decoder_accum #(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8,
  localparam int N     = 1 << CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_onehot,
  output logic [CODE_W-1:0] out_code,
  input  logic [N-1:0]      clr_mask,
  output logic [N-1:0]      pending,
  output logic [CODE_W-1:0] top_code,
  output logic              top_valid,
  output logic              dup_err,
  input  logic              err_clr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  event_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          accept;
  logic [N-1:0]  set_vec;
  logic          dup_hit;

  // The output register drains in the same cycle it is refilled, so a full
  // stage still accepts whenever downstream is taking the current result.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign set_vec  = accept ? (N'(1) << in_code) : '0;
  assign dup_hit  = accept && pending[in_code] && !clr_mask[in_code];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_code   <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_onehot <= N'(1) << in_code;
      out_code   <= in_code;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_code   <= '0;
    end
  end

  // Set is OR-ed after the clear so a same-cycle set/clear on one bit keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_err <= 1'b0;
    end else begin
      dup_err <= dup_hit || (dup_err && !err_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= '0;
    end else if (cnt_clr) begin
      event_count <= accept ? CNT_W'(1) : '0;
    end else if (accept && event_count != CNT_MAX) begin
      event_count <= event_count + CNT_W'(1);
    end
  end

  // Ascending scan: the last set bit seen is the highest, giving top priority
  // to the highest index, matching the companion priority encoder.
  // NOTE: top_code gets a default before the loop so no latch is inferred.
  always_comb begin
    top_code = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) top_code = CODE_W'(i);
    end
  end

  assign top_valid = |pending;

endmodule

// File: tb/tb_code_decoder_accum.sv
// Directed bench for code_decoder_accum; a second instance with CNT_W=2
// exercises counter saturation.
module tb_code_decoder_accum;

  localparam int CODE_W = 3;
  localparam int N      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              out_ready;
  logic [N-1:0]      clr_mask;
  logic              err_clr;
  logic              cnt_clr;

  logic              in_ready, out_valid, top_valid, dup_err;
  logic [N-1:0]      out_onehot, pending;
  logic [CODE_W-1:0] out_code, top_code;
  logic [7:0]        event_count;

  logic              s_in_ready, s_out_valid, s_top_valid, s_dup_err;
  logic [N-1:0]      s_out_onehot, s_pending;
  logic [CODE_W-1:0] s_out_code, s_top_code;
  logic [1:0]        s_event_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_decoder_accum #(.CODE_W(CODE_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_code(out_code), .clr_mask(clr_mask),
    .pending(pending), .top_code(top_code), .top_valid(top_valid),
    .dup_err(dup_err), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .event_count(event_count)
  );

  code_decoder_accum #(.CODE_W(CODE_W), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_code(in_code), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_onehot(s_out_onehot), .out_code(s_out_code), .clr_mask(clr_mask),
    .pending(s_pending), .top_code(s_top_code), .top_valid(s_top_valid),
    .dup_err(s_dup_err), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .event_count(s_event_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_mask  = '1;
    err_clr   = 1'b1;
    cnt_clr   = 1'b1;
    step();
    clr_mask  = '0;
    err_clr   = 1'b0;
    cnt_clr   = 1'b0;
    step();
  endtask

  initial begin
    logic [CODE_W-1:0] enc;
    logic [N-1:0]      vec;

    // Reset with a valid code already presented.
    rst = 1'b1; in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1;
    clr_mask = '0; err_clr = 1'b0; cnt_clr = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_onehot", out_onehot, 0);
    check("rst_out_code", out_code, 0);
    check("rst_pending", pending, 0);
    check("rst_top", {top_valid, top_code}, 0);
    check("rst_dup", dup_err, 0);
    check("rst_cnt", event_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    step();
    check("first_onehot", out_onehot, 8'h20);
    check("first_code", out_code, 5);
    check("first_valid", out_valid, 1);
    check("first_pending", pending, 8'h20);
    check("first_top", {top_valid, top_code}, {1'b1, 3'd5});
    check("first_cnt", event_count, 1);

    // Back-to-back codes at full throughput.
    clear_all();
    in_valid = 1'b1;
    in_code = 3'd0; step(); check("b2b_0", out_onehot, 8'h01);
    in_code = 3'd3; step(); check("b2b_3", out_onehot, 8'h08);
    in_code = 3'd7; step(); check("b2b_7", out_onehot, 8'h80);
    in_valid = 1'b0;
    check("b2b_pending", pending, 8'h89);
    check("b2b_top", top_code, 7);
    check("b2b_cnt", event_count, 3);
    check("b2b_dup", dup_err, 0);

    // Backpressure holds the result and stalls input.
    clear_all();
    in_valid = 1'b1; in_code = 3'd2; step();
    check("bp_first", out_onehot, 8'h04);
    in_code = 3'd6; out_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", in_ready, 0);
      step();
      check("bp_hold_onehot", out_onehot, 8'h04);
      check("bp_hold_valid", out_valid, 1);
    end
    check("bp_ready_last", in_ready, 0);
    out_ready = 1'b1; #1;
    check("bp_ready_rel", in_ready, 1);
    step();
    check("bp_new_onehot", out_onehot, 8'h40);
    check("bp_new_code", out_code, 6);
    check("bp_pending", pending, 8'h44);
    in_valid = 1'b0; step();
    check("bp_drain", out_valid, 0);

    // Duplicate detection, clear, and set/clear priority.
    clear_all();
    in_valid = 1'b1; in_code = 3'd4; step();
    check("dup_none", dup_err, 0);
    step();
    check("dup_set", dup_err, 1);
    in_valid = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
    check("dup_cleared", dup_err, 0);
    in_valid = 1'b1; clr_mask = 8'h10; step();
    in_valid = 1'b0; clr_mask = '0;
    check("dup_masked", dup_err, 0);
    check("dup_set_wins", pending, 8'h10);
    in_valid = 1'b1; err_clr = 1'b1; step();
    in_valid = 1'b0; err_clr = 1'b0;
    check("dup_over_clr", dup_err, 1);

    // Counter saturation on the narrow instance, and clear priorities.
    clear_all();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code = 3'(i);
      step();
      check("sat_cnt", s_event_count, (i < 3) ? i + 1 : 3);
    end
    check("wide_cnt", event_count, 5);
    cnt_clr = 1'b1; step();
    check("clr_acc_small", s_event_count, 1);
    check("clr_acc_wide", event_count, 1);
    in_valid = 1'b0; step(); cnt_clr = 1'b0;
    check("clr_only", event_count, 0);

    // Asynchronous reset while a result is stalled.
    clear_all();
    in_valid = 1'b1; in_code = 3'd3; out_ready = 1'b0; step();
    check("mid_held", out_valid, 1);
    in_valid = 1'b0; #2; rst = 1'b1; #1;
    check("mid_valid", out_valid, 0);
    check("mid_onehot", out_onehot, 0);
    check("mid_pending", pending, 0);
    check("mid_cnt", event_count, 0);
    check("mid_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;

    // Round trip of every valid priority-encoder output.
    clear_all();
    for (int v = 1; v < 256; v++) begin
      vec = 8'(v);
      enc = '0;
      for (int b = 0; b < N; b++) if (vec[b]) enc = 3'(b);
      in_valid = 1'b1; in_code = enc; clr_mask = '1;
      step();
      check("rt_top", top_code, enc);
      check("rt_onehot", out_onehot, 32'(1) << enc);
    end
    in_valid = 1'b0; clr_mask = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
